// File: rtl/temp_display_sel_n_pkg.sv
// temp_disp_pkg: mode encodings, state type and default dwell for the temperature display selector
package temp_disp_pkg;
  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_AUTO = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;
  localparam int DEFAULT_DWELL_CYCLES = 100_000_000;
  typedef enum logic [1:0] {ST_MANUAL, ST_AUTO, ST_HOLD} state_t;
  function automatic state_t decode_mode(input logic [1:0] m);
    return m == MODE_AUTO ? ST_AUTO : m == MODE_HOLD ? ST_HOLD : ST_MANUAL;
  endfunction
endpackage

// File: rtl/temp_display_sel_n_dwell_timer.sv
// dwell_timer: per-channel dwell counter that freezes when disabled and resumes from its held value
module dwell_timer
  import temp_disp_pkg::*;
#(
  parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES
)(
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);
  logic [CW-1:0] count;
  assign tick = enable && count == LAST;
  always_ff @(posedge CLK100MHZ)
    if (reset || clear) count <= '0;
    else if (enable) count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/temp_display_sel_n.sv
// temp_display_sel_n: registers one of NUM_CH temperature words with manual, auto-scroll and hold modes
module temp_display_sel_n
  import temp_disp_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 8,
  parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  localparam int SEL_W = $clog2(NUM_CH)
)(
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  input  logic [1:0]              mode_sw,
  input  logic [SEL_W-1:0]        selectionSW,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  output logic [WIDTH-1:0]        display_reg,
  output logic [SEL_W-1:0]        display_ch,
  output logic                    update_pulse
);
  state_t state, state_next;
  logic tick, sel_ok;
  logic [SEL_W-1:0] ch_inc, ch_next;
  logic [WIDTH-1:0] data_next;
  dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
    .CLK100MHZ(CLK100MHZ),
    .reset(reset),
    .enable(state_next == ST_AUTO),
    .clear(state_next == ST_MANUAL && state != ST_MANUAL),
    .tick(tick)
  );
  always_comb begin
    state_next = decode_mode(mode_sw);
    sel_ok = int'(selectionSW) < NUM_CH;
    ch_inc = display_ch == SEL_W'(NUM_CH - 1) ? '0 : display_ch + 1'b1;
    ch_next = state_next == ST_AUTO ? (tick ? ch_inc : display_ch) :
              state_next == ST_MANUAL && sel_ok ? selectionSW : display_ch;
    data_next = ch_data[int'(ch_next)*WIDTH +: WIDTH];
  end
  always_ff @(posedge CLK100MHZ)
    if (reset) begin
      state <= ST_MANUAL;
      display_reg <= '0;
      display_ch <= '0;
      update_pulse <= 1'b0;
    end else begin
      state <= state_next;
      update_pulse <= state_next != ST_HOLD && (data_next != display_reg || ch_next != display_ch);
      if (state_next != ST_HOLD) begin
        display_reg <= data_next;
        display_ch <= ch_next;
      end
    end
endmodule
